// File: rtl/object_draw_if.sv
// Command and pixel bus between the game control path and the object draw engine.
// The master drives draw commands and receives the pixel stream and status.
interface object_draw_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [3:0]     cmd_state;
    logic [Y_W-1:0] bird_y;
    logic [X_W-1:0] wall_x;
    logic [Y_W-1:0] gap_y;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [2:0]     colour;
    logic           plot;
    logic           done;
    logic           collision;

    modport master (
        output cmd_valid, cmd_state, bird_y, wall_x, gap_y,
        input  cmd_ready, x, y, colour, plot, done, collision
    );

    modport slave (
        input  cmd_valid, cmd_state, bird_y, wall_x, gap_y,
        output cmd_ready, x, y, colour, plot, done, collision
    );
endinterface

// File: rtl/object_draw_engine.sv
// Raster-scans the bird or wall rectangle one pixel per cycle for the VGA adapter,
// pulses done per command and keeps a sticky bird/wall collision flag.
module object_draw_engine #(
    parameter int         X_W         = 8,
    parameter int         Y_W         = 7,
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter int         BIRD_X      = 20,
    parameter int         BIRD_W      = 4,
    parameter int         BIRD_H      = 4,
    parameter int         WALL_W      = 8,
    parameter int         GAP_H       = 32,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    parameter logic [2:0] BIRD_COLOUR = 3'b110,
    parameter logic [2:0] WALL_COLOUR = 3'b010
) (
    input logic         clk,
    input logic         resetn,
    object_draw_if.slave bus
);

    localparam logic [3:0] CMD_ERASE_BIRD = 4'b0001;
    localparam logic [3:0] CMD_DRAW_BIRD  = 4'b0010;
    localparam logic [3:0] CMD_ERASE_WALL = 4'b0011;
    localparam logic [3:0] CMD_DRAW_WALL  = 4'b0100;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_next;
    logic [3:0]     cmd_q;
    logic [Y_W-1:0] bird_y_q, gap_y_q;
    logic [X_W-1:0] wall_x_q;
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;

    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic [2:0]     colour_q;
    logic           plot_q, done_q, collision_q, hit_q;

    logic           cmd_ready_int, accept, cmd_is_draw;
    logic           is_bird, last_col, last_row, in_gap, visible;
    logic [X_W-1:0] base_x, width;
    logic [Y_W-1:0] base_y, height;
    logic [X_W:0]   sum_x;
    logic [Y_W:0]   sum_y, gap_lo, gap_hi;
    logic [2:0]     colour_sel;
    logic [X_W:0]   wall_lo, wall_hi;
    logic [Y_W:0]   bird_top, live_gap_lo;
    logic           hit_cols, hit_rows;

    // Ready drops while the done pulse is still showing so a new command never overlaps it.
    assign cmd_ready_int = (state == IDLE) && !done_q;
    assign accept        = bus.cmd_valid && cmd_ready_int;
    assign cmd_is_draw   = (bus.cmd_state == CMD_ERASE_BIRD) || (bus.cmd_state == CMD_DRAW_BIRD) ||
                           (bus.cmd_state == CMD_ERASE_WALL) || (bus.cmd_state == CMD_DRAW_WALL);

    assign bus.cmd_ready = cmd_ready_int;
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.colour    = colour_q;
    assign bus.plot      = plot_q;
    assign bus.done      = done_q;
    assign bus.collision = collision_q;

    always_comb begin
        is_bird  = (cmd_q == CMD_ERASE_BIRD) || (cmd_q == CMD_DRAW_BIRD);
        base_x   = is_bird ? X_W'(BIRD_X) : wall_x_q;
        base_y   = is_bird ? bird_y_q : '0;
        width    = is_bird ? X_W'(BIRD_W) : X_W'(WALL_W);
        height   = is_bird ? Y_W'(BIRD_H) : Y_W'(SCREEN_H);
        last_col = (dx == width - 1'b1);
        last_row = (dy == height - 1'b1);
        // Sums are one bit wider so off-screen pixels are caught before truncation.
        sum_x    = {1'b0, base_x} + {1'b0, dx};
        sum_y    = {1'b0, base_y} + {1'b0, dy};
        gap_lo   = {1'b0, gap_y_q};
        gap_hi   = gap_lo + (Y_W+1)'(GAP_H);
        in_gap   = !is_bird && (sum_y >= gap_lo) && (sum_y < gap_hi);
        visible  = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H)) && !in_gap;
        case (cmd_q)
            CMD_DRAW_BIRD: colour_sel = BIRD_COLOUR;
            CMD_DRAW_WALL: colour_sel = WALL_COLOUR;
            default:       colour_sel = BG_COLOUR;
        endcase
    end

    // Collision uses the live wall position presented with the DRAW_BIRD command.
    always_comb begin
        wall_lo     = {1'b0, bus.wall_x};
        wall_hi     = wall_lo + (X_W+1)'(WALL_W - 1);
        hit_cols    = ((X_W+1)'(BIRD_X) <= wall_hi) && (wall_lo <= (X_W+1)'(BIRD_X + BIRD_W - 1));
        bird_top    = {1'b0, bus.bird_y};
        live_gap_lo = {1'b0, bus.gap_y};
        hit_rows    = (bird_top < live_gap_lo) ||
                      ((bird_top + (Y_W+1)'(BIRD_H)) > (live_gap_lo + (Y_W+1)'(GAP_H)));
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = cmd_is_draw ? RUN : DONE;
            RUN:     if (last_col && last_row) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cmd_q       <= '0;
            bird_y_q    <= '0;
            wall_x_q    <= '0;
            gap_y_q     <= '0;
            dx          <= '0;
            dy          <= '0;
            x_q         <= '0;
            y_q         <= '0;
            colour_q    <= '0;
            plot_q      <= 1'b0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            done_q      <= (state == DONE);
            plot_q      <= 1'b0;
            hit_q       <= 1'b0;
            collision_q <= collision_q | hit_q;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_q    <= bus.cmd_state;
                        bird_y_q <= bus.bird_y;
                        wall_x_q <= bus.wall_x;
                        gap_y_q  <= bus.gap_y;
                        dx       <= '0;
                        dy       <= '0;
                        hit_q    <= (bus.cmd_state == CMD_DRAW_BIRD) && hit_cols && hit_rows;
                    end
                end
                RUN: begin
                    x_q      <= sum_x[X_W-1:0];
                    y_q      <= sum_y[Y_W-1:0];
                    colour_q <= colour_sel;
                    plot_q   <= visible;
                    if (last_col) begin
                        dx <= '0;
                        dy <= dy + 1'b1;
                    end else begin
                        dx <= dx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_object_draw_engine.sv
// Directed self-checking bench for object_draw_engine: bird/wall scans, clipping,
// collision, busy handling, mid-command reset and NOP commands.
module tb_object_draw_engine;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    object_draw_if #(.X_W(8), .Y_W(7)) bus();

    object_draw_engine dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for ready, then holds the command for exactly one accepting edge.
    task automatic start_cmd(input logic [3:0] code, input logic [6:0] by,
                             input logic [7:0] wx, input logic [6:0] gy);
        int waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 2000) begin
            step();
            waited++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_timeout cmd_ready=%b required 1", bus.cmd_ready);
        end
        bus.cmd_state = code;
        bus.bird_y    = by;
        bus.wall_x    = wx;
        bus.gap_y     = gy;
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        step();
        checks++; if (bus.plot !== 1'b0)      begin errors++; $display("[TB] FAIL reset_plot got %b want 0", bus.plot); end
        checks++; if (bus.done !== 1'b0)      begin errors++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.collision !== 1'b0) begin errors++; $display("[TB] FAIL reset_collision got %b want 0", bus.collision); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", bus.cmd_ready); end
        checks++; if (bus.x !== 8'd0 || bus.y !== 7'd0 || bus.colour !== 3'd0) begin
            errors++; $display("[TB] FAIL reset_pixel got x=%0d y=%0d c=%0d want 0 0 0", bus.x, bus.y, bus.colour);
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_draw_bird();
        logic [7:0] ex;
        logic [6:0] ey;
        start_cmd(4'b0010, 7'd10, 8'd100, 7'd40);
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL bird_busy_ready got %b want 0", bus.cmd_ready); end
        for (int k = 1; k <= 18; k++) begin
            step();
            checks++; if (bus.plot !== (k <= 16)) begin errors++; $display("[TB] FAIL bird_plot cycle N+%0d got %b want %b", k, bus.plot, (k <= 16)); end
            checks++; if (bus.done !== (k == 17)) begin errors++; $display("[TB] FAIL bird_done cycle N+%0d got %b want %b", k, bus.done, (k == 17)); end
            checks++; if (bus.cmd_ready !== (k == 18)) begin errors++; $display("[TB] FAIL bird_ready cycle N+%0d got %b want %b", k, bus.cmd_ready, (k == 18)); end
            if (k <= 16) begin
                ex = 8'(20 + (k - 1) % 4);
                ey = 7'(10 + (k - 1) / 4);
                checks++;
                if (bus.x !== ex || bus.y !== ey || bus.colour !== 3'b110) begin
                    errors++;
                    $display("[TB] FAIL bird_pixel cycle N+%0d got (%0d,%0d,c%0d) want (%0d,%0d,c6)", k, bus.x, bus.y, bus.colour, ex, ey);
                end
            end
        end
    endtask

    // Each cycle k carries counter i=k-1 (dx=i%8, dy=i/8); gap rows 40..71.
    task automatic test_wall_scan(input logic [7:0] wx, input int exp_plots);
        int bad = 0, plots = 0, done_at = 0, dx, dy, xw;
        logic ep;
        start_cmd(4'b0100, 7'd0, wx, 7'd40);
        for (int k = 1; k <= 963; k++) begin
            step();
            if (k <= 960) begin
                dx = (k - 1) % 8;
                dy = (k - 1) / 8;
                xw = int'(wx) + dx;
                ep = (xw < 160) && !(dy >= 40 && dy < 72);
                if (bus.plot !== ep) bad++;
                if (ep && (bus.x !== 8'(xw) || bus.y !== 7'(dy) || bus.colour !== 3'b010)) bad++;
            end else if (bus.plot !== 1'b0) begin
                bad++;
            end
            if (bus.plot === 1'b1) plots++;
            if (bus.done === 1'b1) begin
                if (done_at == 0) done_at = k;
                else bad++;
            end
        end
        checks++; if (plots != exp_plots) begin errors++; $display("[TB] FAIL wall_plots wall_x=%0d got %0d want %0d", wx, plots, exp_plots); end
        checks++; if (done_at != 961)     begin errors++; $display("[TB] FAIL wall_done wall_x=%0d got N+%0d want N+961", wx, done_at); end
        checks++; if (bad != 0)           begin errors++; $display("[TB] FAIL wall_pixels wall_x=%0d bad=%0d want 0", wx, bad); end
    endtask

    // Bird rows 118..121: the two rows at and past the screen bottom are suppressed.
    task automatic test_erase_clip();
        int plots = 0, bad = 0;
        start_cmd(4'b0001, 7'd118, 8'd100, 7'd40);
        for (int k = 1; k <= 17; k++) begin
            step();
            if (bus.plot !== (k <= 8)) bad++;
            if (bus.plot === 1'b1) begin
                plots++;
                if (bus.colour !== 3'b000) bad++;
            end
        end
        checks++; if (plots != 8) begin errors++; $display("[TB] FAIL erase_clip_plots got %0d want 8", plots); end
        checks++; if (bad != 0)   begin errors++; $display("[TB] FAIL erase_clip_pixels bad=%0d want 0", bad); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL erase_clip_done got %b want 1", bus.done); end
    endtask

    task automatic test_collision();
        start_cmd(4'b0010, 7'd30, 8'd18, 7'd40);
        step();
        checks++; if (bus.collision !== 1'b1) begin errors++; $display("[TB] FAIL collision_set got %b want 1", bus.collision); end
        start_cmd(4'b0010, 7'd10, 8'd100, 7'd40);
        for (int k = 0; k < 20; k++) step();
        checks++; if (bus.collision !== 1'b1) begin errors++; $display("[TB] FAIL collision_sticky got %b want 1", bus.collision); end
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        checks++; if (bus.collision !== 1'b0) begin errors++; $display("[TB] FAIL collision_reset got %b want 0", bus.collision); end
        start_cmd(4'b0010, 7'd50, 8'd18, 7'd40);
        step();
        checks++; if (bus.collision !== 1'b0) begin errors++; $display("[TB] FAIL collision_in_gap got %b want 0", bus.collision); end
        for (int k = 0; k < 20; k++) step();
        checks++; if (bus.collision !== 1'b0) begin errors++; $display("[TB] FAIL collision_in_gap_late got %b want 0", bus.collision); end
    endtask

    task automatic test_back_to_back();
        int dones = 0, done_k = 0;
        start_cmd(4'b0010, 7'd10, 8'd100, 7'd40);
        for (int k = 1; k <= 25; k++) begin
            if (k == 5) begin
                bus.cmd_state = 4'b1111;
                bus.cmd_valid = 1'b1;
            end
            if (k == 6) bus.cmd_valid = 1'b0;
            step();
            if (bus.done === 1'b1) begin
                dones++;
                done_k = k;
            end
        end
        checks++; if (dones != 1)   begin errors++; $display("[TB] FAIL busy_done_count got %0d want 1", dones); end
        checks++; if (done_k != 17) begin errors++; $display("[TB] FAIL busy_done_cycle got N+%0d want N+17", done_k); end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        start_cmd(4'b0010, 7'd10, 8'd100, 7'd40);
        for (int k = 1; k <= 8; k++) step();
        checks++; if (bus.plot !== 1'b1) begin errors++; $display("[TB] FAIL mid_pixel8_plot got %b want 1", bus.plot); end
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        checks++; if (bus.plot !== 1'b0)      begin errors++; $display("[TB] FAIL mid_reset_plot got %b want 0", bus.plot); end
        checks++; if (bus.done !== 1'b0)      begin errors++; $display("[TB] FAIL mid_reset_done got %b want 0", bus.done); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_ready got %b want 1", bus.cmd_ready); end
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.done === 1'b1 || bus.plot === 1'b1) dones++;
        end
        checks++; if (dones != 0)             begin errors++; $display("[TB] FAIL mid_reset_activity got %0d want 0", dones); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_idle_ready got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_nop();
        start_cmd(4'b1111, 7'd10, 8'd100, 7'd40);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL nop_done_early got %b want 0", bus.done); end
        step();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL nop_done got %b want 1", bus.done); end
        checks++; if (bus.plot !== 1'b0) begin errors++; $display("[TB] FAIL nop_plot got %b want 0", bus.plot); end
        step();
        checks++; if (bus.done !== 1'b0)      begin errors++; $display("[TB] FAIL nop_done_after got %b want 0", bus.done); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL nop_ready got %b want 1", bus.cmd_ready); end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_state = 4'd0;
        bus.bird_y    = 7'd0;
        bus.wall_x    = 8'd0;
        bus.gap_y     = 7'd0;
        resetn        = 1'b0;
        test_reset();
        test_draw_bird();
        test_wall_scan(8'd100, 704);
        test_wall_scan(8'd156, 352);
        test_erase_clip();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        test_nop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/object_draw_engine.md
Name: object_draw_engine

Overview:
- Pixel-level drawing datapath for the flappy-bird game. Consumes the 4-bit object state codes issued by the game control path (bird/wall erase/draw) through a valid/ready handshake.
- Raster-scans the addressed object rectangle and emits one pixel per cycle (x, y, colour, plot) to the VGA adapter.
- Pulses done when a command completes and maintains the sticky bird/wall collision flag.

Parameters:
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- SCREEN_W, 160, visible columns; pixels with x >= SCREEN_W are suppressed
- SCREEN_H, 120, visible rows (wall height)
- BIRD_X, 20, fixed bird left column
- BIRD_W, 4, bird width in pixels
- BIRD_H, 4, bird height in pixels
- WALL_W, 8, wall width in pixels
- GAP_H, 32, height of the wall gap
- BG_COLOUR, 3'b000, colour used for erase commands
- BIRD_COLOUR, 3'b110, colour used for bird draw
- WALL_COLOUR, 3'b010, colour used for wall draw

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_state  in  4  command code: 0001 ERASE_BIRD, 0010 DRAW_BIRD, 0011 ERASE_WALL, 0100 DRAW_WALL; all other codes are NOP
- bird_y  in  Y_W  bird top row
- wall_x  in  X_W  wall left column
- gap_y  in  Y_W  first row of the wall gap
- x  out  X_W  pixel x
- y  out  Y_W  pixel y
- colour  out  3  pixel colour
- plot  out  1  pixel write strobe
- done  out  1  one-cycle command-complete pulse
- collision  out  1  sticky collision flag

Behaviour:
- Reset (resetn=0 at a clk edge):
  - All outputs go to 0. FSM enters IDLE. Counters clear. collision clears.
  - Reset mid-command aborts the command; no done pulse is produced.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1.
  - A transfer occurs when cmd_valid && cmd_ready at a clk edge.
  - On transfer, latch cmd_state, bird_y, wall_x and gap_y. Clear dx and dy.
  - Go to RUN for draw/erase codes. Go to DONE for NOP codes.
- cmd_ready=0 in RUN and DONE. cmd_valid is ignored there and is neither queued nor latched.
- RUN:
  - Bird commands: base = (BIRD_X, latched bird_y), size BIRD_W x BIRD_H.
  - Wall commands: base = (latched wall_x, 0), size WALL_W x SCREEN_H.
  - Scan order is row-major: dx increments each cycle; when dx = w-1, dx wraps to 0 and dy increments.
  - When the last pixel (dx=w-1, dy=h-1) is issued, go to DONE.
- Pixel outputs are registered:
  - The pixel for counter (dx,dy) appears on x/y/colour/plot in the cycle after the counters hold that value.
  - The first pixel appears in the cycle after acceptance.
  - x = base_x + dx and y = base_y + dy. Sums are computed one bit wider and truncated for output.
- plot is suppressed (0) when any of the following holds:
  - the wide x sum >= SCREEN_W;
  - the wide y sum >= SCREEN_H;
  - for wall commands only, gap_y <= y < gap_y + GAP_H, compared at Y_W+1 bits.
- Colour: BG_COLOUR for erase commands, BIRD_COLOUR for DRAW_BIRD, WALL_COLOUR for DRAW_WALL.
- DONE:
  - done=1 for exactly one cycle. It coincides with the cycle after the last pixel's output cycle.
  - plot=0 in DONE.
  - Next state is IDLE.
- Latency for a command accepted at edge N:
  - Bird: pixels occupy cycles N+1..N+16, done at N+17, cmd_ready high from N+18.
  - Wall: pixels occupy cycles N+1..N+960, done at N+961.
  - NOP: done at N+1.
- Collision:
  - Evaluated only on an accepted DRAW_BIRD, using the live wall_x and gap_y inputs at acceptance. Registered, so visible at N+1.
  - Set to 1 when both hold:
    - column overlap: [BIRD_X, BIRD_X+BIRD_W-1] intersects [wall_x, wall_x+WALL_W-1];
    - rows not fully inside the gap: bird_y < gap_y, or bird_y+BIRD_H > gap_y+GAP_H.
  - Once set, it stays 1 until reset.

Test Plan:
- Reset: hold resetn=0 for 2 cycles -> plot=0, done=0, collision=0, cmd_ready=1.
- DRAW_BIRD, bird_y=10, accepted at edge N -> plot=1 on cycles N+1..N+16.
  - First pixel (20,10), last pixel (23,13), colour 3'b110.
  - done=1 only at N+17; cmd_ready=1 at N+18.
- DRAW_WALL, wall_x=100, gap_y=40 -> exactly 704 plot pulses, colour 3'b010, none with y in 40..71.
  - x spans 100..107; done at N+961.
- Clipping with DRAW_WALL, wall_x=156 -> plots only at x 156..159; 960-cycle timing unchanged.
- Collision cases:
  - DRAW_BIRD, bird_y=30, wall_x=18, gap_y=40 -> collision=1 at N+1.
  - Later DRAW_BIRD with no overlap -> collision stays 1.
  - Same geometry as the first case but bird_y=50 -> collision stays 0.
- Busy and reset cases:
  - cmd_valid pulsed mid-bird draw -> ignored, no extra done.
  - resetn=0 at pixel 8 -> plot=0 next cycle, no done, IDLE with cmd_ready=1.
  - NOP code 4'b1111 -> done at N+1, no plot.
